// File: rtl/kws_audio_framer.sv
// kws_audio_framer: buffers 16-bit PCM samples, cuts them into overlapping
// frames of FRAME_LEN samples advancing by HOP, and streams each frame to
// the KWS accelerator with a start pulse followed by a valid/ready stream.
// Optional feature macro: FRAMER_PREEMPH_EN (pre-emphasis, alpha = 31/32).
module kws_audio_framer #(
    parameter int DEPTH     = 512,
    parameter int FRAME_LEN = 400,
    parameter int HOP       = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pcm_sample,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    output logic        start,
    output logic [15:0] audio_sample,
    output logic        sample_valid,
    input  logic        sample_ready,
    input  logic        accel_done,
    output logic [15:0] frame_idx,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W     = (AW+1)'(DEPTH);
    localparam logic [AW:0] FRAME_LEN_W = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0] HOP_W       = (AW+1)'(HOP);
    localparam logic [AW:0] LAST_RD_W   = (AW+1)'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_DONE
    } state_t;

    logic [15:0]   mem [DEPTH];
    state_t        state_reg;
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   base_ptr_reg;
    logic [AW:0]   rd_cnt_reg;
    logic [AW:0]   rd_cnt_next;
    logic [AW:0]   occupancy;
    logic [AW:0]   rd_ofs;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          start_reg;
    logic          sample_valid_reg;
    logic [15:0]   audio_sample_reg;
    logic [15:0]   frame_idx_reg;
    logic          overflow_reg;
    logic [15:0]   stored_sample;

    // Pointers carry one extra wrap bit so a full buffer is distinguishable from empty.
    assign occupancy = wr_ptr_reg - base_ptr_reg;
    assign pcm_ready = (occupancy < DEPTH_W);
    assign wr_en     = pcm_valid && pcm_ready;
    assign wr_addr   = wr_ptr_reg[AW-1:0];

    assign start        = start_reg;
    assign sample_valid = sample_valid_reg;
    assign audio_sample = audio_sample_reg;
    assign frame_idx    = frame_idx_reg;
    assign overflow     = overflow_reg;

    // Read address: frame head when launching, otherwise the sample after the current one.
    always_comb begin
        rd_cnt_next = rd_cnt_reg + 1'b1;
        rd_ofs      = (state_reg == S_START) ? '0 : rd_cnt_next;
        rd_addr     = base_ptr_reg[AW-1:0] + rd_ofs[AW-1:0];
    end

`ifdef FRAMER_PREEMPH_EN
    logic signed [15:0] x_prev_reg;
    logic signed [15:0] prev_shift;
    logic signed [17:0] x_ext;
    logic signed [17:0] prev_ext;
    logic signed [17:0] shift_ext;
    logic signed [17:0] emph_diff;

    // y = x - alpha*x_prev in 18 bits, then saturate back to 16 bits.
    always_comb begin
        prev_shift = x_prev_reg >>> 5;
        x_ext      = {{2{pcm_sample[15]}}, pcm_sample};
        prev_ext   = {{2{x_prev_reg[15]}}, x_prev_reg};
        shift_ext  = {{2{prev_shift[15]}}, prev_shift};
        emph_diff  = x_ext - (prev_ext - shift_ext);
        if (emph_diff > 18'sd32767) begin
            stored_sample = 16'h7FFF;
        end else if (emph_diff < -18'sd32768) begin
            stored_sample = 16'h8000;
        end else begin
            stored_sample = emph_diff[15:0];
        end
    end

    // Filter history advances only on samples actually written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_prev_reg <= '0;
        end else if (wr_en) begin
            x_prev_reg <= pcm_sample;
        end
    end
`else
    assign stored_sample = pcm_sample;
`endif

    // Sample buffer write port; contents need no reset since pointers gate validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= stored_sample;
        end
    end

    // Write pointer, overflow flag and frame sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            wr_ptr_reg       <= '0;
            base_ptr_reg     <= '0;
            rd_cnt_reg       <= '0;
            start_reg        <= 1'b0;
            sample_valid_reg <= 1'b0;
            audio_sample_reg <= '0;
            frame_idx_reg    <= '0;
            overflow_reg     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pcm_valid && !pcm_ready) begin
                overflow_reg <= 1'b1;
            end
            start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (occupancy >= FRAME_LEN_W && !accel_done) begin
                        start_reg <= 1'b1;
                        state_reg <= S_START;
                    end
                end
                S_START: begin
                    rd_cnt_reg       <= '0;
                    sample_valid_reg <= 1'b1;
                    audio_sample_reg <= mem[rd_addr];
                    state_reg        <= S_STREAM;
                end
                S_STREAM: begin
                    if (sample_ready) begin
                        if (rd_cnt_reg == LAST_RD_W) begin
                            sample_valid_reg <= 1'b0;
                            state_reg        <= S_WAIT_DONE;
                        end else begin
                            rd_cnt_reg       <= rd_cnt_next;
                            audio_sample_reg <= mem[rd_addr];
                        end
                    end
                end
                S_WAIT_DONE: begin
                    // Commit the hop: the overlap stays buffered for the next frame.
                    if (accel_done) begin
                        base_ptr_reg  <= base_ptr_reg + HOP_W;
                        frame_idx_reg <= frame_idx_reg + 16'd1;
                        state_reg     <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kws_audio_framer.sv
// Directed testbench for kws_audio_framer at DEPTH=16, FRAME_LEN=8, HOP=4.
module tb_kws_audio_framer;
    logic        clk;
    logic        rst;
    logic [15:0] pcm_sample;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        start;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        accel_done;
    logic [15:0] frame_idx;
    logic        overflow;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [15:0] model [64];
    int wr_idx = 0;

    kws_audio_framer #(.DEPTH(16), .FRAME_LEN(8), .HOP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pcm_sample   (pcm_sample),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .start        (start),
        .audio_sample (audio_sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .accel_done   (accel_done),
        .frame_idx    (frame_idx),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Offer one sample; record its expected stored value only if it will be accepted.
    task automatic push(input logic [15:0] x, input logic [15:0] y);
        pcm_sample = x;
        pcm_valid  = 1'b1;
        if (pcm_ready) begin
            model[wr_idx] = y;
            wr_idx++;
        end
        @(posedge clk); #1;
        pcm_valid = 1'b0;
    endtask

    task automatic wait_start();
        int cyc = 0;
        while (!start && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("start_pulse", start, 1);
        @(posedge clk); #1;
        check_val("start_width", start, 0);
        check_val("first_valid", sample_valid, 1);
    endtask

    task automatic pulse_done();
        repeat (2) @(posedge clk);
        #1;
        accel_done = 1'b1;
        @(posedge clk); #1;
        accel_done = 1'b0;
    endtask

    // Collect one frame, expecting model[first .. first+7]; optionally toggle ready.
    task automatic run_frame(input int first, input bit toggle, input logic [15:0] exp_idx);
        int n = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [15:0] held = '0;
        wait_start();
        while (n < 8 && cyc < 100) begin
            if (toggle) sample_ready = cyc[0];
            if (sample_valid) begin
                if (stalled) check_val("hold", audio_sample, held);
                if (sample_ready) begin
                    check_val($sformatf("f%0d_s%0d", exp_idx, n), audio_sample, model[first + n]);
                    n++;
                    stalled = 1'b0;
                end else begin
                    held    = audio_sample;
                    stalled = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        sample_ready = 1'b1;
        check_val("handshakes", n, 8);
        check_val("valid_drop", sample_valid, 0);
        pulse_done();
        check_val("frame_idx", frame_idx, exp_idx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_idx = 0;
    endtask

    initial begin
        rst          = 1'b1;
        pcm_sample   = '0;
        pcm_valid    = 1'b0;
        sample_ready = 1'b1;
        accel_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", pcm_ready, 1);
        check_val("rst_start", start, 0);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_audio", audio_sample, 0);
        check_val("rst_idx", frame_idx, 0);
        check_val("rst_ovf", overflow, 0);
        rst = 1'b0;

`ifdef FRAMER_PREEMPH_EN
        push(16'd1000, 16'd1000);
        push(16'd1000, 16'd31);
        push(16'h7FFF, 16'd31798);
        push(16'h8000, 16'h8000);
        push(16'd0, 16'd31744);
        for (int i = 0; i < 3; i++) push(16'd0, 16'd0);
        run_frame(0, 1'b0, 16'd1);
        do_reset();
`else
        // Frames 1 and 2: overlap of FRAME_LEN-HOP samples.
        for (int i = 0; i < 8; i++) push(16'(i), 16'(i));
        run_frame(0, 1'b0, 16'd1);
        for (int i = 8; i < 12; i++) push(16'(i), 16'(i));
        run_frame(4, 1'b0, 16'd2);
        // Frame 3 under a ready toggling every cycle.
        for (int i = 12; i < 16; i++) push(16'(i), 16'(i));
        run_frame(8, 1'b1, 16'd3);
        // Reset in the middle of frame 4 at rd_cnt=3.
        for (int i = 16; i < 20; i++) push(16'(i), 16'(i));
        wait_start();
        check_val("mid_s0", audio_sample, model[12]);
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_s3", audio_sample, model[15]);
        rst = 1'b1;
        #1;
        check_val("abort_valid", sample_valid, 0);
        check_val("abort_idx", frame_idx, 0);
        check_val("abort_ready", pcm_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        wr_idx = 0;
        for (int i = 0; i < 8; i++) push(16'(50 + i), 16'(50 + i));
        run_frame(0, 1'b0, 16'd1);
        do_reset();
`endif

        // Fill to capacity with no commit, then overflow.
        for (int i = 0; i < 15; i++) push(16'(i), 16'(i));
        check_val("ready_at_15", pcm_ready, 1);
        push(16'd15, 16'd15);
        check_val("ready_at_16", pcm_ready, 0);
        check_val("ovf_before", overflow, 0);
        push(16'd16, 16'd16);
        check_val("ovf_set", overflow, 1);
        repeat (5) @(posedge clk);
        #1;
        check_val("ovf_sticky", overflow, 1);
        pulse_done();
        check_val("ovf_idx", frame_idx, 1);
        check_val("ovf_after_commit", overflow, 1);
        check_val("ready_after_commit", pcm_ready, 1);
        do_reset();
        check_val("ovf_cleared", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
